// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug read-out engine for the CPU register file. A start pulse in IDLE
//   walks addresses 0..Nloc-1 through a spare register-file read port and
//   streams each {address, data} pair over a valid/ready handshake. The
//   register file is only ever read.
//
// Ports
//   clock      : single clock, all state changes on its rising edge
//   reset_n    : synchronous active-low reset
//   start      : request a full dump (only looked at in IDLE)
//   abort      : end a dump in progress at the next edge
//   ReadAddr   : address driven to the register-file read port
//   ReadData   : combinational data returned by that port
//   out_addr   : address of the word being presented
//   out_data   : register value being presented
//   out_valid  : out_addr/out_data are valid
//   out_ready  : consumer takes the word when out_valid & out_ready at an edge
//   busy       : high whenever the engine is not IDLE
//   done       : one-cycle pulse after the last word or after an abort
module reg_dump_reader #(
  parameter int Abits = 5,
  parameter int Dbits = 32,
  parameter int Nloc  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic [Abits-1:0] ReadAddr,
  input  logic [Dbits-1:0] ReadData,
  output logic [Abits-1:0] out_addr,
  output logic [Dbits-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [Abits-1:0] LastAddr = Abits'(Nloc - 1);

  state_t state;
  state_t nextState;
  logic   accept;

  assign accept = out_valid & out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) nextState = READ;
      end
      READ: begin
        nextState = abort ? FINISH : PRESENT;
      end
      PRESENT: begin
        // An acceptance in the same cycle as abort still counts as delivered;
        // abort simply prevents the walk from continuing.
        if (abort) begin
          nextState = FINISH;
        end else if (accept) begin
          nextState = (ReadAddr == LastAddr) ? FINISH : READ;
        end
      end
      FINISH: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Address counter and presented-word registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ReadAddr  <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) ReadAddr <= '0;
        end
        READ: begin
          // ReadData is only captured here, with ReadAddr held for the cycle.
          if (abort) begin
            out_valid <= 1'b0;
          end else begin
            out_data  <= ReadData;
            out_addr  <= ReadAddr;
            out_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (abort || accept) out_valid <= 1'b0;
          // The counter stops at the last address rather than wrapping.
          if (!abort && accept && (ReadAddr != LastAddr)) begin
            ReadAddr <= ReadAddr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state != IDLE)   busy = 1'b1;
    if (state == FINISH) done = 1'b1;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [4:0]  ReadAddr;
  logic [31:0] ReadData;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  reg_dump_reader #(.Abits(5), .Dbits(32), .Nloc(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .ReadAddr (ReadAddr),
    .ReadData (ReadData),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: r0 reads 0, ri reads 0x100+i
  function automatic logic [31:0] regVal(input int a);
    return (a == 0) ? 32'h0 : 32'h100 + a;
  endfunction

  assign ReadData = regVal(int'(ReadAddr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a dump and plays consumer until done or the cycle budget expires.
  // abortAt: address at which to abort with out_ready low (99 = never).
  task automatic runDump(input int abortAt, input bit rndReady, input bit holdStart,
                         output int words, output int cyc);
    int          expAddr;
    bit          hold;
    logic [4:0]  hAddr;
    logic [31:0] hData;
    words   = 0;
    cyc     = 0;
    expAddr = 0;
    hold    = 0;
    hAddr   = '0;
    hData   = '0;
    start   = 1'b1;
    step();
    start = holdStart;
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(ReadAddr), 32'd0);
    check("start_valid", 32'(out_valid), 32'd0);
    while (!done && cyc < 400) begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_addr", 32'(out_addr), 32'(hAddr));
        check("hold_data", out_data, hData);
      end
      if (ReadAddr > 5'd31) check("addr_range", 32'(ReadAddr), 32'd31);
      out_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      abort     = 1'b0;
      if (out_valid && int'(out_addr) == abortAt) begin
        out_ready = 1'b0;
        abort     = 1'b1;
      end
      if (out_valid && out_ready) begin
        check("word_addr", 32'(out_addr), 32'(expAddr));
        check("word_data", out_data, regVal(expAddr));
        expAddr++;
        words++;
      end
      hold  = out_valid && !out_ready && !abort;
      hAddr = out_addr;
      hData = out_data;
      step();
      cyc++;
    end
    abort     = 1'b0;
    out_ready = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("finish_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int words;
    int cyc;
    int n;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_raddr", 32'(ReadAddr), 32'd0);
    check("rst_oaddr", 32'(out_addr), 32'd0);
    check("rst_odata", out_data, 32'd0);
    reset_n = 1'b1;
    step();

    // Full dump, consumer always ready: 64 edges from start edge to FINISH
    runDump(99, 1'b0, 1'b0, words, cyc);
    check("full_words", 32'(words), 32'd32);
    check("full_cycles", 32'(cyc), 32'd64);
    step();
    check("full_idle_busy", 32'(busy), 32'd0);
    check("full_idle_done", 32'(done), 32'd0);

    // Random back-pressure
    runDump(99, 1'b1, 1'b0, words, cyc);
    check("rnd_words", 32'(words), 32'd32);
    step();
    check("rnd_idle_busy", 32'(busy), 32'd0);

    // Abort while presenting address 5 with out_ready low
    runDump(5, 1'b0, 1'b0, words, cyc);
    check("abort_words", 32'(words), 32'd5);
    check("abort_cycles", 32'(cyc), 32'd12);
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);

    // Reset while presenting address 10
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    out_ready = 1'b1;
    while (!(out_valid && out_addr == 5'd10) && n < 100) begin
      step();
      n++;
    end
    check("rstmid_at10", 32'(out_addr), 32'd10);
    check("rstmid_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    reset_n   = 1'b0;
    step();
    check("rstmid_valid0", 32'(out_valid), 32'd0);
    check("rstmid_oaddr0", 32'(out_addr), 32'd0);
    check("rstmid_odata0", out_data, 32'd0);
    check("rstmid_raddr0", 32'(ReadAddr), 32'd0);
    check("rstmid_busy0", 32'(busy), 32'd0);
    check("rstmid_done0", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    check("rstmid_nodone", 32'(done), 32'd0);
    runDump(99, 1'b0, 1'b0, words, cyc);
    check("rstmid_words", 32'(words), 32'd32);
    step();

    // Start held high: back-to-back dumps with one IDLE cycle between
    runDump(99, 1'b0, 1'b1, words, cyc);
    check("hold1_words", 32'(words), 32'd32);
    check("hold1_cycles", 32'(cyc), 32'd64);
    step();
    check("hold_gap_busy", 32'(busy), 32'd0);
    runDump(99, 1'b0, 1'b1, words, cyc);
    check("hold2_words", 32'(words), 32'd32);
    start = 1'b0;
    step();
    check("end_busy", 32'(busy), 32'd0);
    step();
    check("end_stay_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
